ret_nop_injector: RTL and testbench

Issue-path block between the decoder output and the issue stage. It forwards scoreboard entries through a one-entry registered stage with a valid/ready handshake. After every function return it inserts one marker NOP entry, which is the pattern the return-tracking parser further down the pipe looks for. It produces the return-followed-by-marker sequence in hardware, so no compiler-inserted NOPs are needed.

---
 rtl/ret_nop_injector_if.sv | 68 ++++++
 rtl/ret_nop_injector.sv | 149 ++++++++++++++
 tb/tb_ret_nop_injector.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ret_nop_injector_if.sv
// ret_nop_injector_if.sv
// Scoreboard-entry types shared by the issue path, and the valid/ready
// entry channel used on both sides of ret_nop_injector.
//   master : drives entry/valid, samples ready (producer side)
//   slave  : samples entry/valid, drives ready (consumer side)

package ariane_pkg;

    // Functional unit that executes an entry.
    typedef enum logic [3:0] {
        NONE,
        LOAD,
        STORE,
        ALU,
        CTRL_FLOW,
        MULT,
        CSR
    } fu_t;

    // Operation carried by an entry.
    typedef enum logic [7:0] {
        ADD,
        SUB,
        ANDL,
        ORL,
        XORL,
        SLTS,
        JALR,
        BEQ
    } fu_op;

    // Exception attached to an entry; valid=1 means the entry faulted.
    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    // One decoded instruction on its way to the issue stage.
    typedef struct packed {
        logic [63:0] pc;
        logic [2:0]  trans_id;
        fu_t         fu;
        fu_op        op;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        logic [5:0]  rd;
        logic [63:0] result;
        logic        valid;
        logic        use_imm;
        logic        use_zimm;
        logic        use_pc;
        exception_t  ex;
        logic        is_compressed;
    } scoreboard_entry_t;

endpackage

interface ret_nop_injector_if;
    import ariane_pkg::*;

    scoreboard_entry_t entry;
    logic              valid;
    logic              ready;

    modport master (output entry, output valid, input ready);
    modport slave  (input entry, input valid, output ready);
endinterface

// File: rtl/ret_nop_injector.sv
// ret_nop_injector.sv
// One-entry registered stage between decode and issue. Entries pass through
// with a valid/ready handshake; every function return (JALR x0, 0(x1) without
// an exception) is followed by one marker NOP carrying the return's pc, which
// the downstream return-tracking parser keys on.
//
// Optional feature macro: RET_NOP_INJECT_CNT_EN
//   defined   : 16-bit saturating count of injected markers on inject_count_o,
//               low byte mirrored on debug_leds_o[7:0].
//   undefined : no counter; inject_count_o and debug_leds_o[7:0] read zero.

module ret_nop_injector
    import ariane_pkg::*;
#(
    parameter fu_op       NOP_OP  = ariane_pkg::ADD,
    parameter logic [4:0] NOP_RD  = 5'b0,
    parameter logic [4:0] NOP_RS1 = 5'b0,
    parameter logic [4:0] NOP_IMM = 5'b1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    ret_nop_injector_if.slave          up_if,   // entry_i / entry_valid_i / entry_ready_o
    ret_nop_injector_if.master         dn_if,   // entry_o / entry_valid_o / entry_ready_i
    output logic [15:0]                inject_count_o,
    output logic [9:0]                 debug_leds_o
);

    typedef enum logic {
        S_PASS,
        S_INJECT
    } state_e;

    state_e            state_q;
    scoreboard_entry_t out_q;
    logic              out_valid_q;
    logic [63:0]       ret_pc_q;
    logic              led_ret_q;
    logic              led_nop_q;

    logic              out_fire;
    logic              accept;
    logic              is_return;
    logic              marker_load;
    scoreboard_entry_t marker;

    // Handshake terms: upstream is stalled while a marker is pending or flushing.
    assign out_fire     = out_valid_q & dn_if.ready;
    assign up_if.ready  = !flush_i && (state_q == S_PASS) && (!out_valid_q || dn_if.ready);
    assign accept       = up_if.valid & up_if.ready;
    assign is_return    = !up_if.entry.ex.valid
                          && (up_if.entry.op  == JALR)
                          && (up_if.entry.rd  == 6'd0)
                          && (up_if.entry.rs1 == 6'd1);
    assign marker_load  = !flush_i && (state_q == S_INJECT) && (!out_valid_q || out_fire);

    assign dn_if.entry  = out_q;
    assign dn_if.valid  = out_valid_q;

    // Build the marker NOP for the most recently accepted return.
    always_comb begin
        // NOTE: every field gets a value before the selective overrides below,
        // so no path leaves a bit unassigned and no latch is inferred.
        marker         = '0;
        marker.pc      = ret_pc_q;
        marker.fu      = ALU;
        marker.op      = NOP_OP;
        marker.rd      = {1'b0, NOP_RD};
        marker.rs1     = {1'b0, NOP_RS1};
        marker.result  = {59'd0, NOP_IMM};
        marker.use_imm = 1'b1;
    end

    // Pass/inject FSM owning the output register and the debug toggles.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the output entry register is reset too, because downstream
            // observes entry_o directly and it must read all-zero after reset.
            state_q     <= S_PASS;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ret_pc_q    <= '0;
            led_ret_q   <= 1'b0;
            led_nop_q   <= 1'b0;
        end else if (flush_i) begin
            // Flush wins: drop the held entry and any pending marker.
            state_q     <= S_PASS;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register
            // here samples the pre-edge values of the others.
            case (state_q)
                S_PASS: begin
                    if (accept) begin
                        out_q       <= up_if.entry;
                        out_valid_q <= 1'b1;
                        if (is_return) begin
                            state_q   <= S_INJECT;
                            ret_pc_q  <= up_if.entry.pc;
                            led_ret_q <= ~led_ret_q;
                        end
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                    end
                end
                S_INJECT: begin
                    if (marker_load) begin
                        out_q       <= marker;
                        out_valid_q <= 1'b1;
                        state_q     <= S_PASS;
                        led_nop_q   <= ~led_nop_q;
                    end
                end
                default: begin
                    state_q <= S_PASS;
                end
            endcase
        end
    end

`ifdef RET_NOP_INJECT_CNT_EN
    logic [15:0] inject_cnt_q;
    logic [15:0] inject_cnt_d;

    // Saturating increment on each marker load.
    always_comb begin
        inject_cnt_d = inject_cnt_q;
        if (marker_load && (inject_cnt_q != 16'hFFFF)) begin
            inject_cnt_d = inject_cnt_q + 16'd1;
        end
    end

    // Marker counter register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inject_cnt_q <= '0;
        end else begin
            inject_cnt_q <= inject_cnt_d;
        end
    end

    assign inject_count_o = inject_cnt_q;
`else
    assign inject_count_o = '0;
`endif

    assign debug_leds_o = {led_nop_q, led_ret_q, inject_count_o[7:0]};

endmodule

// File: tb/tb_ret_nop_injector.sv
// tb_ret_nop_injector.sv
// Self-checking bench for ret_nop_injector: a directed vector table, hand
// sequences for stall / flush / saturation / reset, and a randomized run
// checked against an ordered queue of expected output entries.

module tb_ret_nop_injector;
    import ariane_pkg::*;

`ifdef RET_NOP_INJECT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [15:0] cnt;
    logic [9:0]  leds;

    always #5 clk = ~clk;

    ret_nop_injector_if up_if ();
    ret_nop_injector_if dn_if ();

    ret_nop_injector dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .flush_i        (flush),
        .up_if          (up_if),
        .dn_if          (dn_if),
        .inject_count_o (cnt),
        .debug_leds_o   (leds)
    );

    int          nvec = 0;
    int          nerr = 0;
    logic [15:0] exp_cnt = '0;
    logic        ret_par = 1'b0;
    logic        nop_par = 1'b0;
    scoreboard_entry_t exp_q[$];

    typedef struct {
        logic              vi;
        scoreboard_entry_t ent;
        logic              ri;
        logic              e_ro;
        logic              e_vo;
        scoreboard_entry_t e_ent;
    } vec_t;

    vec_t vecs[12];

    function automatic scoreboard_entry_t mk(fu_op op, logic [5:0] rd, logic [5:0] rs1,
                                             logic exv, logic [63:0] pc);
        scoreboard_entry_t e;
        e          = '0;
        e.fu       = (op == JALR) ? CTRL_FLOW : ALU;
        e.op       = op;
        e.rd       = rd;
        e.rs1      = rs1;
        e.rs2      = 6'd3;
        e.result   = 64'hDEAD;
        e.trans_id = 3'd2;
        e.ex.valid = exv;
        e.pc       = pc;
        return e;
    endfunction

    function automatic scoreboard_entry_t marker_of(logic [63:0] pc);
        scoreboard_entry_t e;
        e         = '0;
        e.op      = ADD;
        e.fu      = ALU;
        e.result  = 64'd1;
        e.use_imm = 1'b1;
        e.pc      = pc;
        return e;
    endfunction

    function automatic bit is_ret(scoreboard_entry_t e);
        return !e.ex.valid && e.op == JALR && e.rd == 6'd0 && e.rs1 == 6'd1;
    endfunction

    function automatic scoreboard_entry_t rand_ent();
        logic [63:0] pc;
        pc = {32'h8000_0000, $urandom};
        if ($urandom_range(0, 2) == 0)
            return mk(JALR, 6'd0, 6'd1, $urandom_range(0, 5) == 0, pc);
        return mk(fu_op'(8'($urandom_range(0, 7))), 6'($urandom_range(0, 2)),
                  6'($urandom_range(0, 2)), $urandom_range(0, 5) == 0, pc);
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_ent(string name, scoreboard_entry_t act, scoreboard_entry_t exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got op=%0d pc=%h rd=%0d rs1=%0d res=%h imm=%b exv=%b, expected op=%0d pc=%h rd=%0d rs1=%0d res=%h imm=%b exv=%b (t=%0t)",
                     name, act.op, act.pc, act.rd, act.rs1, act.result, act.use_imm, act.ex.valid,
                     exp.op, exp.pc, exp.rd, exp.rs1, exp.result, exp.use_imm, exp.ex.valid, $time);
        end
    endtask

    task automatic note_marker();
        nop_par = ~nop_par;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    task automatic check_status(string tag);
        logic [15:0] ec;
        ec = CNT_EN ? exp_cnt : 16'd0;
        check({tag, "_count"}, 64'(cnt), 64'(ec));
        check({tag, "_leds"}, 64'(leds), 64'({nop_par, ret_par, ec[7:0]}));
    endtask

    task automatic idle_inputs();
        up_if.valid = 1'b0;
        up_if.entry = '0;
        flush       = 1'b0;
    endtask

    // One observed cycle of the randomized run, at negedge+1.
    task automatic observe();
        if (dn_if.valid) begin
            check("queue_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) check_ent("stream_order", dn_if.entry, exp_q[0]);
            if (dn_if.ready && exp_q.size() != 0) void'(exp_q.pop_front());
        end
        if (up_if.valid && up_if.ready) begin
            exp_q.push_back(up_if.entry);
            if (is_ret(up_if.entry)) begin
                exp_q.push_back(marker_of(up_if.entry.pc));
                ret_par = ~ret_par;
                note_marker();
            end
        end
    endtask

    task automatic one_return(logic [63:0] pc);
        up_if.valid = 1'b1;
        up_if.entry = mk(JALR, 6'd0, 6'd1, 1'b0, pc);
        dn_if.ready = 1'b1;
        @(negedge clk);
        up_if.valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ret_par = ~ret_par;
        note_marker();
    endtask

    initial begin
        scoreboard_entry_t e0, e1, e2, r, e4, call, xr, r2, r3;
        rst = 1'b1;
        dn_if.ready = 1'b0;
        idle_inputs();

        e0   = mk(ADD, 6'd5, 6'd6, 1'b0, 64'h100);
        e1   = mk(ADD, 6'd7, 6'd8, 1'b0, 64'h104);
        e2   = mk(ADD, 6'd9, 6'd10, 1'b0, 64'h108);
        r    = mk(JALR, 6'd0, 6'd1, 1'b0, 64'h8000_0010);
        e4   = mk(ADD, 6'd1, 6'd2, 1'b0, 64'h200);
        call = mk(JALR, 6'd1, 6'd1, 1'b0, 64'h300);
        xr   = mk(JALR, 6'd0, 6'd1, 1'b1, 64'h304);

        vecs[0]  = '{1'b1, e0,   1'b1, 1'b1, 1'b0, '0};
        vecs[1]  = '{1'b1, e1,   1'b1, 1'b1, 1'b1, e0};
        vecs[2]  = '{1'b1, e2,   1'b1, 1'b1, 1'b1, e1};
        vecs[3]  = '{1'b1, r,    1'b1, 1'b1, 1'b1, e2};
        vecs[4]  = '{1'b1, e4,   1'b1, 1'b0, 1'b1, r};
        vecs[5]  = '{1'b1, e4,   1'b1, 1'b1, 1'b1, marker_of(64'h8000_0010)};
        vecs[6]  = '{1'b0, '0,   1'b1, 1'b1, 1'b1, e4};
        vecs[7]  = '{1'b0, '0,   1'b1, 1'b1, 1'b0, '0};
        vecs[8]  = '{1'b1, call, 1'b1, 1'b1, 1'b0, '0};
        vecs[9]  = '{1'b1, xr,   1'b1, 1'b1, 1'b1, call};
        vecs[10] = '{1'b0, '0,   1'b1, 1'b1, 1'b1, xr};
        vecs[11] = '{1'b0, '0,   1'b1, 1'b1, 1'b0, '0};

        // Reset values
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_valid_o", 64'(dn_if.valid), 64'd0);
        check_ent("rst_entry_o", dn_if.entry, '0);
        check("rst_ready_o", 64'(up_if.ready), 64'd1);
        check_status("rst");

        // Directed table: stream, return + marker, call, faulting return
        for (int i = 0; i < 12; i++) begin
            up_if.valid = vecs[i].vi;
            up_if.entry = vecs[i].ent;
            dn_if.ready = vecs[i].ri;
            #1;
            check($sformatf("vec%0d_ready_o", i), 64'(up_if.ready), 64'(vecs[i].e_ro));
            check($sformatf("vec%0d_valid_o", i), 64'(dn_if.valid), 64'(vecs[i].e_vo));
            if (vecs[i].e_vo) check_ent($sformatf("vec%0d_entry_o", i), dn_if.entry, vecs[i].e_ent);
            @(negedge clk);
        end
        ret_par = ~ret_par;
        note_marker();
        check_status("table");

        // Return held by a 4-cycle downstream stall
        r2 = mk(JALR, 6'd0, 6'd1, 1'b0, 64'h8000_0040);
        up_if.valid = 1'b1;
        up_if.entry = r2;
        dn_if.ready = 1'b0;
        #1;
        check("stall_accept_ready", 64'(up_if.ready), 64'd1);
        @(negedge clk);
        up_if.valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_ent("stall_hold", dn_if.entry, r2);
            check("stall_valid", 64'(dn_if.valid), 64'd1);
            check("stall_ready_o", 64'(up_if.ready), 64'd0);
            @(negedge clk);
        end
        dn_if.ready = 1'b1;
        #1;
        check_ent("stall_release", dn_if.entry, r2);
        check("stall_release_ready_o", 64'(up_if.ready), 64'd0);
        @(negedge clk);
        #1;
        check_ent("stall_marker", dn_if.entry, marker_of(64'h8000_0040));
        check("stall_marker_valid", 64'(dn_if.valid), 64'd1);
        check("stall_marker_ready_o", 64'(up_if.ready), 64'd1);
        @(negedge clk);
        #1;
        check("stall_drained", 64'(dn_if.valid), 64'd0);
        ret_par = ~ret_par;
        note_marker();
        check_status("stall");
        @(negedge clk);

        // Flush while a marker is pending
        r3 = mk(JALR, 6'd0, 6'd1, 1'b0, 64'h8000_0080);
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.entry = r3;
        @(negedge clk);
        up_if.valid = 1'b0;
        #1;
        check_ent("flush_pre_entry", dn_if.entry, r3);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_ready_o", 64'(up_if.ready), 64'd0);
        @(negedge clk);
        flush = 1'b0;
        dn_if.ready = 1'b1;
        #1;
        check("flush_valid_o", 64'(dn_if.valid), 64'd0);
        check("flush_state_pass", 64'(up_if.ready), 64'd1);
        @(negedge clk);
        #1;
        check("flush_no_marker", 64'(dn_if.valid), 64'd0);
        ret_par = ~ret_par;
        check_status("flush");
        @(negedge clk);

        // Flush in the same cycle as a return: nothing accepted
        flush = 1'b1;
        up_if.valid = 1'b1;
        up_if.entry = r3;
        #1;
        check("flush_same_ready_o", 64'(up_if.ready), 64'd0);
        @(negedge clk);
        idle_inputs();
        #1;
        check("flush_same_valid_o", 64'(dn_if.valid), 64'd0);
        @(negedge clk);
        #1;
        check("flush_same_no_marker", 64'(dn_if.valid), 64'd0);
        check_status("flush_same");
        @(negedge clk);

        // Randomized traffic against the ordered-queue model
        for (int c = 0; c < 400; c++) begin
            up_if.valid = ($urandom_range(0, 3) != 0);
            up_if.entry = rand_ent();
            dn_if.ready = ($urandom_range(0, 3) != 0);
            #1;
            observe();
            @(negedge clk);
        end
        up_if.valid = 1'b0;
        dn_if.ready = 1'b1;
        for (int c = 0; c < 20 && (exp_q.size() != 0 || dn_if.valid); c++) begin
            #1;
            observe();
            @(negedge clk);
        end
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        check("drain_valid_o", 64'(dn_if.valid), 64'd0);
        check_status("random");

        // Counter saturation
`ifdef RET_NOP_INJECT_CNT_EN
        force dut.inject_cnt_q = 16'hFFFE;
        #1;
        release dut.inject_cnt_q;
        exp_cnt = 16'hFFFE;
        #1;
        check_status("preset");
        @(negedge clk);
`endif
        one_return(64'h8000_1000);
        one_return(64'h8000_2000);
        one_return(64'h8000_3000);
        #1;
        check_status("saturate");
        @(negedge clk);

        // Reset while a marker is pending
        dn_if.ready = 1'b0;
        up_if.valid = 1'b1;
        up_if.entry = mk(JALR, 6'd0, 6'd1, 1'b0, 64'h8000_0100);
        @(negedge clk);
        up_if.valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dn_if.ready = 1'b1;
        exp_cnt = '0;
        ret_par = 1'b0;
        nop_par = 1'b0;
        #1;
        check("mrst_valid_o", 64'(dn_if.valid), 64'd0);
        check_ent("mrst_entry_o", dn_if.entry, '0);
        check("mrst_ready_o", 64'(up_if.ready), 64'd1);
        check_status("mrst");
        @(negedge clk);
        #1;
        check("mrst_marker_lost", 64'(dn_if.valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
